// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel multiplexer.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_ch_pick.sv
// Finds the next enabled channel above the current one, wrapping to 0.
// If no other channel is enabled the current index is returned unchanged.
module scan_mux_ch_pick #(
  parameter int N_CH = 4,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [SELW-1:0] cur_i,
  input  logic [N_CH-1:0] ch_en_i,
  output logic [SELW-1:0] nxt_o,
  output logic            wrapped_o,
  output logic            none_o
);

  // Walk the ring starting just above cur; the first enabled hit wins.
  always_comb begin
    int              idx;
    logic [SELW-1:0] idx_s;
    logic            found;
    idx       = 0;
    idx_s     = '0;
    found     = 1'b0;
    nxt_o     = cur_i;
    for (int k = 1; k < N_CH; k++) begin
      idx = int'(cur_i) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_s = SELW'(idx);
      if (!found && ch_en_i[idx_s]) begin
        found = 1'b1;
        nxt_o = idx_s;
      end
    end
    wrapped_o = found && (nxt_o < cur_i);
    none_o    = ~|ch_en_i;
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with manual select, masked round-robin scan
// with a dwell time, and an output freeze (hold).
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_CH  = 4,
  parameter  int DWELL = 4,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [N_CH*WIDTH-1:0] din_i,
  input  logic [SELW-1:0]       sel_i,
  input  logic                  mode_i,
  input  logic                  hold_i,
  input  logic [N_CH-1:0]       ch_en_i,
  output logic [WIDTH-1:0]      m_o,
  output logic [SELW-1:0]       ch_o,
  output logic                  valid_o,
  output logic                  wrap_o,
  output logic                  sel_err_o
);

  localparam int              DCW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0]  DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [SELW:0]   NCH_W      = (SELW+1)'(N_CH);

  state_t                      state_q, state_d;
  logic [SELW-1:0]             ch_q, ch_d;
  logic [WIDTH-1:0]            m_q, m_d;
  logic [DCW-1:0]              dwell_q, dwell_d;
  logic                        valid_q, valid_d;
  logic                        wrap_q, wrap_d;
  logic                        err_q, err_d;

  logic [N_CH-1:0][WIDTH-1:0]  din_v;
  logic [SELW-1:0]             pick_nxt;
  logic                        pick_wrapped, pick_none;

  assign din_v = din_i;

  scan_mux_ch_pick #(.N_CH(N_CH), .SELW(SELW)) u_pick (
    .cur_i    (ch_q),
    .ch_en_i  (ch_en_i),
    .nxt_o    (pick_nxt),
    .wrapped_o(pick_wrapped),
    .none_o   (pick_none)
  );

  // Next-state: hold freezes everything, otherwise mode picks manual or scan.
  // Entering scan from manual keeps the current channel and restarts dwell;
  // coming back from hold resumes the frozen dwell count.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    valid_d = 1'b1;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (hold_i) begin
      state_d = ST_HOLD;
      valid_d = 1'b0;
    end else if (mode_i == MODE_MANUAL) begin
      state_d = ST_MANUAL;
      dwell_d = '0;
      if ({1'b0, sel_i} < NCH_W) ch_d = sel_i;
      else                       err_d = 1'b1;
    end else begin
      state_d = ST_SCAN;
      if (state_q == ST_MANUAL) begin
        dwell_d = '0;
      end else if (dwell_q == DWELL_LAST || !ch_en_i[ch_q]) begin
        dwell_d = '0;
        ch_d    = pick_nxt;
        wrap_d  = pick_wrapped & ~pick_none;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    m_d = hold_i ? m_q : din_v[ch_d];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_MANUAL;
      ch_q    <= '0;
      m_q     <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      m_q     <= m_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign m_o       = m_q;
  assign ch_o      = ch_q;
  assign valid_o   = valid_q;
  assign wrap_o    = wrap_q;
  assign sel_err_o = err_q;

endmodule
